// File: rtl/alu_pkg.sv
// Shared opcode encoding (CPU ID-stage) and mul/div engine state type.
package alu_pkg;

   localparam logic [4:0] OpLd   = 5'd0;
   localparam logic [4:0] OpLdi  = 5'd1;
   localparam logic [4:0] OpSt   = 5'd2;
   localparam logic [4:0] OpAdd  = 5'd3;
   localparam logic [4:0] OpSub  = 5'd4;
   localparam logic [4:0] OpAnd  = 5'd5;
   localparam logic [4:0] OpOr   = 5'd6;
   localparam logic [4:0] OpRor  = 5'd7;
   localparam logic [4:0] OpRol  = 5'd8;
   localparam logic [4:0] OpShr  = 5'd9;
   localparam logic [4:0] OpShra = 5'd10;
   localparam logic [4:0] OpShl  = 5'd11;
   localparam logic [4:0] OpAddi = 5'd12;
   localparam logic [4:0] OpAndi = 5'd13;
   localparam logic [4:0] OpOri  = 5'd14;
   localparam logic [4:0] OpDiv  = 5'd15;
   localparam logic [4:0] OpMul  = 5'd16;
   localparam logic [4:0] OpNeg  = 5'd17;
   localparam logic [4:0] OpNot  = 5'd18;
   localparam logic [4:0] OpBr   = 5'd19;
   localparam logic [4:0] OpNop  = 5'd26;
   localparam logic [4:0] OpHalt = 5'd27;

   typedef enum logic [1:0] {
      MdIdle,
      MdPrep,
      MdIter,
      MdFix
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide engine: PREP -> ITER x WIDTH -> FIX.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic               clk_i,
   input  logic               clear_i,
   input  logic               start_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               idle_o,
   output logic               done_o,
   output logic               div_zero_o,
   output logic [2*WIDTH-1:0] result_o
);

   localparam int unsigned SHW = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic               is_div_q, is_div_d, sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d;

   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0]   a_abs, b_abs, quot, rem;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      sgn_q_d   = sgn_q_q;
      sgn_r_d   = sgn_r_q;
      a_abs     = (SIGNED && a_q[WIDTH-1]) ? -a_q : a_q;
      b_abs     = (SIGNED && b_q[WIDTH-1]) ? -b_q : b_q;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, b_q};
      case (state_q)
         MdIdle: begin
            if (start_i) begin
               a_d      = a_i;
               b_d      = b_i;
               is_div_d = is_div_i;
               state_d  = MdPrep;
            end
         end
         MdPrep: begin
            acc_d   = {{WIDTH{1'b0}}, a_abs};
            b_d     = b_abs;
            sgn_q_d = SIGNED && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            sgn_r_d = SIGNED && a_q[WIDTH-1];
            cnt_d   = SHW'(WIDTH - 1);
            state_d = (is_div_q && (b_q == '0)) ? MdFix : MdIter;
         end
         MdIter: begin
            if (is_div_q) begin
               // Non-negative difference (sign bit clear) means the subtract sticks.
               acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = MdFix;
            end
         end
         MdFix: begin
            state_d = MdIdle;
         end
         default: begin
            state_d = MdIdle;
         end
      endcase
   end

   always_comb begin
      prod       = sgn_q_q ? -acc_q : acc_q;
      quot       = sgn_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem        = sgn_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      div_zero_o = is_div_q && (b_q == '0);
      if (div_zero_o) begin
         quot = '1;
         rem  = a_q;
      end
      result_o = is_div_q ? {rem, quot} : prod;
      idle_o   = (state_q == MdIdle);
      done_o   = (state_q == MdFix);
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         state_q  <= MdIdle;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         sgn_q_q  <= 1'b0;
         sgn_r_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sgn_q_q  <= sgn_q_d;
         sgn_r_q  <= sgn_r_d;
      end
   end

endmodule

// File: rtl/alu_mc_n.sv
// Multi-cycle ALU top: single-cycle datapath, opcode decode and registered outputs.
module alu_mc_n
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          SIGNED = 1'b1
) (
   input  logic               Clock,
   input  logic               Clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         Control,
   input  logic               Branch,
   input  logic               IncrementPC,
   input  logic [WIDTH-1:0]   reg_A,
   input  logic [WIDTH-1:0]   reg_B,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] reg_C,
   output logic               div_zero,
   output logic               unknown_op
);

   localparam int unsigned SHW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] c_q, c_d, md_result;
   logic               ov_q, ov_d, dz_q, dz_d, uo_q, uo_d;
   logic               accept, md_start, md_idle, md_done, md_dz;
   logic [WIDTH-1:0]   sc_res;
   logic               sc_hit;
   logic [SHW-1:0]     shamt;
   logic [SHW:0]       shinv;

   assign accept = in_valid && in_ready;
   assign shamt  = reg_B[SHW-1:0];
   // WIDTH is a power of two, so {1, 0...0} equals WIDTH; shinv = WIDTH - shamt.
   assign shinv  = {1'b1, {SHW{1'b0}}} - {1'b0, shamt};

   always_comb begin
      sc_res = '0;
      sc_hit = 1'b1;
      case (Control)
         OpLd, OpLdi, OpSt, OpAdd, OpAddi: sc_res = reg_A + reg_B;
         OpSub:         sc_res = reg_A - reg_B;
         OpAnd, OpAndi: sc_res = reg_A & reg_B;
         OpOr, OpOri:   sc_res = reg_A | reg_B;
         OpNot:         sc_res = ~reg_B;
         OpNeg:         sc_res = -reg_B;
         OpShl:         sc_res = reg_A << shamt;
         OpShr:         sc_res = reg_A >> shamt;
         OpShra:        sc_res = $signed(reg_A) >>> shamt;
         OpRol:         sc_res = (reg_A << shamt) | (reg_A >> shinv);
         OpRor:         sc_res = (reg_A >> shamt) | (reg_A << shinv);
         OpBr:          sc_res = Branch ? reg_A + reg_B : reg_A;
         default:       sc_hit = 1'b0;
      endcase
   end

   always_comb begin
      c_d      = c_q;
      ov_d     = 1'b0;
      dz_d     = dz_q;
      uo_d     = uo_q;
      md_start = 1'b0;
      if (md_done) begin
         c_d  = md_result;
         ov_d = 1'b1;
         dz_d = md_dz;
         uo_d = 1'b0;
      end else if (accept) begin
         if (IncrementPC) begin
            c_d  = {{WIDTH{1'b0}}, reg_B + 1'b1};
            ov_d = 1'b1;
            dz_d = 1'b0;
            uo_d = 1'b0;
         end else if (sc_hit) begin
            c_d  = {{WIDTH{1'b0}}, sc_res};
            ov_d = 1'b1;
            dz_d = 1'b0;
            uo_d = 1'b0;
         end else if ((Control == OpMul) || (Control == OpDiv)) begin
            md_start = 1'b1;
         end else if ((Control == OpNop) || (Control == OpHalt)) begin
            ov_d = 1'b1;
            dz_d = 1'b0;
            uo_d = 1'b0;
         end else begin
            c_d  = '0;
            ov_d = 1'b1;
            dz_d = 1'b0;
            uo_d = 1'b1;
         end
      end
   end

   alu_muldiv_iter #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
   ) u_muldiv (
      .clk_i      (Clock),
      .clear_i    (Clear),
      .start_i    (md_start),
      .is_div_i   (Control == OpDiv),
      .a_i        (reg_A),
      .b_i        (reg_B),
      .idle_o     (md_idle),
      .done_o     (md_done),
      .div_zero_o (md_dz),
      .result_o   (md_result)
   );

   always_ff @(posedge Clock) begin
      if (Clear) begin
         c_q  <= '0;
         ov_q <= 1'b0;
         dz_q <= 1'b0;
         uo_q <= 1'b0;
      end else begin
         c_q  <= c_d;
         ov_q <= ov_d;
         dz_q <= dz_d;
         uo_q <= uo_d;
      end
   end

   assign in_ready   = md_idle;
   assign out_valid  = ov_q;
   assign reg_C      = c_q;
   assign div_zero   = dz_q;
   assign unknown_op = uo_q;

endmodule

// File: tb/tb_alu_mc_n.sv
// Self-checking bench for alu_mc_n: latency/result model checked every cycle, plus directed cases.
module tb_alu_mc_n;
   import alu_pkg::*;

   localparam bit SGN = 1'b1;

   logic        clk = 1'b0;
   logic        clear, in_valid, in_ready, branch, inc_pc, out_valid, div_zero, unknown_op;
   logic [4:0]  control;
   logic [31:0] a, b;
   logic [63:0] c;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   alu_mc_n #(
      .WIDTH  (32),
      .SIGNED (SGN)
   ) dut (
      .Clock       (clk),
      .Clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .Control     (control),
      .Branch      (branch),
      .IncrementPC (inc_pc),
      .reg_A       (a),
      .reg_B       (b),
      .out_valid   (out_valid),
      .reg_C       (c),
      .div_zero    (div_zero),
      .unknown_op  (unknown_op)
   );

   typedef struct packed {
      logic [63:0] c;
      logic [63:0] pc;
      logic        ov, dz, uo, pdz;
      logic [7:0]  busy;
   } mstate_t;

   mstate_t m = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   // Reference: result values from plain arithmetic, MUL/DIV as a fixed latency countdown.
   function automatic mstate_t model_next(input mstate_t s, input logic clr, input logic iv,
                                          input logic [4:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic br, input logic inc);
      mstate_t     n = s;
      logic [31:0] r = '0;
      bit          single = 1'b1;
      int          sh = int'(y[4:0]);
      longint      sx, sy, q, rm;
      n.ov = 1'b0;
      if (clr) return '0;
      if (s.busy != 0) begin
         n.busy = s.busy - 1;
         if (n.busy == 0) begin
            n.c  = s.pc;
            n.ov = 1'b1;
            n.dz = s.pdz;
            n.uo = 1'b0;
         end
         return n;
      end
      if (!iv) return n;
      sx = SGN ? longint'($signed(x)) : longint'({32'b0, x});
      sy = SGN ? longint'($signed(y)) : longint'({32'b0, y});
      if (inc) begin
         r = y + 1;
      end else begin
         case (op)
            OpLd, OpLdi, OpSt, OpAdd, OpAddi: r = x + y;
            OpSub:         r = x - y;
            OpAnd, OpAndi: r = x & y;
            OpOr, OpOri:   r = x | y;
            OpNot:         r = ~y;
            OpNeg:         r = -y;
            OpShl:         r = x << sh;
            OpShr:         r = x >> sh;
            OpShra:        r = $signed(x) >>> sh;
            OpRol:         r = (x << sh) | (x >> (32 - sh));
            OpRor:         r = (x >> sh) | (x << (32 - sh));
            OpBr:          r = br ? x + y : x;
            OpMul: begin
               single = 1'b0;
               n.busy = 8'd34;
               n.pc   = 64'(sx * sy);
               n.pdz  = 1'b0;
            end
            OpDiv: begin
               single = 1'b0;
               if (y == 0) begin
                  n.busy = 8'd2;
                  n.pc   = {x, 32'hFFFF_FFFF};
                  n.pdz  = 1'b1;
               end else begin
                  q      = sx / sy;
                  rm     = sx % sy;
                  n.busy = 8'd34;
                  n.pc   = {rm[31:0], q[31:0]};
                  n.pdz  = 1'b0;
               end
            end
            OpNop, OpHalt: begin
               single = 1'b0;
               n.ov   = 1'b1;
               n.dz   = 1'b0;
               n.uo   = 1'b0;
            end
            default: begin
               single = 1'b0;
               n.c    = '0;
               n.ov   = 1'b1;
               n.dz   = 1'b0;
               n.uo   = 1'b1;
            end
         endcase
      end
      if (single) begin
         n.c  = {32'b0, r};
         n.ov = 1'b1;
         n.dz = 1'b0;
         n.uo = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m <= model_next(m, clear, in_valid, control, a, b, branch, inc_pc);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, m.busy == 0);
         check("out_valid", out_valid, m.ov);
         check("reg_C", c, m.c);
         check("div_zero", div_zero, m.dz);
         check("unknown_op", unknown_op, m.uo);
      end
   end

   // Returns at the negedge of the cycle after the accepting edge.
   task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic br, input logic inc);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("issue_ready_timeout", in_ready, 1'b1);
      control  = op;
      a        = x;
      b        = y;
      branch   = br;
      inc_pc   = inc;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      inc_pc   = 1'b0;
   endtask

   // k = cycle index relative to accept cycle N at which out_valid is seen.
   task automatic wait_ov(output int k, output int low);
      k   = 1;
      low = 0;
      while (!out_valid && k < 60) begin
         if (!in_ready) low++;
         @(negedge clk);
         k++;
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int k, low;
      clear = 1'b1;
      in_valid = 1'b0;
      control = OpNop;
      branch = 1'b0;
      inc_pc = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      clear = 1'b0;
      check("rst_reg_C", c, 64'h0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_flags", {div_zero, unknown_op}, 2'b00);
      chk_en = 1'b1;

      issue(OpAdd, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      check("add_carry_ov", out_valid, 1'b1);
      check("add_carry", c, 64'h0);
      issue(OpRor, 32'h1, 32'h21, 1'b0, 1'b0);
      check("ror_amt", c, 64'h0000_0000_8000_0000);
      issue(OpMul, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
      wait_ov(k, low);
      check("mul_latency", k, 35);
      check("mul_busy_cycles", low, 34);
      check("mul_result", c, 64'hFFFF_FFFF_FFFF_FFFE);
      @(negedge clk);
      check("mul_ov_pulse", out_valid, 1'b0);

      issue(OpDiv, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
      wait_ov(k, low);
      check("div_neg", c, 64'hFFFF_FFFE_FFFF_FFF2);
      check("div_neg_dz", div_zero, 1'b0);
      issue(OpDiv, 32'd5, 32'd0, 1'b0, 1'b0);
      wait_ov(k, low);
      check("div0_latency", k, 3);
      check("div0_result", c, 64'h0000_0005_FFFF_FFFF);
      check("div0_flag", div_zero, 1'b1);
      issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_ov(k, low);
      check("div_min", c, 64'h0000_0000_8000_0000);
      check("div_min_flag", div_zero, 1'b0);

      issue(5'd20, 32'd1, 32'd2, 1'b0, 1'b0);
      check("unk_c", c, 64'h0);
      check("unk_flag", unknown_op, 1'b1);
      issue(OpNop, 32'd1, 32'd2, 1'b0, 1'b0);
      check("nop_flag_clr", {out_valid, unknown_op}, 2'b10);

      issue(OpMul, 32'd1234, 32'd5678, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("abort_c", c, 64'h0);
      check("abort_ready", in_ready, 1'b1);
      check("abort_ov", out_valid, 1'b0);
      repeat (40) @(negedge clk);
      issue(OpAdd, 32'd2, 32'd3, 1'b0, 1'b0);
      check("add_after_abort", c, 64'd5);

      issue(OpBr, 32'd100, 32'd20, 1'b1, 1'b0);
      check("br_taken", c, 64'd120);
      issue(OpBr, 32'd100, 32'd20, 1'b0, 1'b0);
      check("br_not_taken", c, 64'd100);
      issue(OpMul, 32'd100, 32'd41, 1'b0, 1'b1);
      check("incpc_over_mul", {out_valid, in_ready, c}, {1'b1, 1'b1, 64'd42});

      for (int i = 0; i < 3000; i++) begin
         clear    = ($urandom_range(299) == 0);
         in_valid = ($urandom_range(9) < 6);
         control  = 5'($urandom_range(31));
         inc_pc   = ($urandom_range(7) == 0);
         branch   = 1'($urandom_range(1));
         a        = pick();
         b        = pick();
         @(negedge clk);
      end
      clear    = 1'b0;
      in_valid = 1'b0;
      repeat (40) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
